wave_seq: RTL and testbench

WAVE_SEQ -- requirements
Module: wave_seq

---
 rtl/wave_seq.sv | 170 +++++++++++++++++
 tb/tb_wave_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq.sv
// wave_seq: table-driven waveform sequencer.
//
// A DEPTH-entry step table holds {en, wr, addr, hold}. On a valid start the
// sequencer walks entries 0..len-1, driving each entry's en/wr/addr for
// hold+1 cycles, then either wraps to entry 0 (loop=1) or returns to idle
// and pulses done (loop=0). stop aborts a run at the next edge.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cfg_we/cfg_idx     table write strobe / entry index
//   cfg_en/wr/addr/hold  entry contents (entry lasts cfg_hold+1 cycles)
//   len, loop          active step count (1..DEPTH) and repeat mode, sampled at start
//   start, stop        launch / abort requests
//   en, wr, addr       registered waveform outputs
//   busy               high while running
//   done               one-cycle pulse on one-shot completion
//   step               index of the entry currently driven
module wave_seq #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [IDX_W:0]    len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic              en,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  step
);

    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [HOLD_W-1:0] hold;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    entry_t tbl [DEPTH];

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W:0]    len_q, len_d;
    logic              loop_q, loop_d;
    logic              en_d, wr_d, done_d;
    logic [ADDR_W-1:0] addr_d;
    logic [IDX_W-1:0]  step_d;

    logic              load, clear;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W:0]    step_inc;
    logic              len_ok;

    // One bit wider than step so the comparison against len (up to DEPTH)
    // cannot wrap.
    assign step_inc = {1'b0, step} + {{IDX_W{1'b0}}, 1'b1};
    assign len_ok   = (len != '0) && (len <= DEPTH_L);
    assign busy     = (state_q == RUN);

    // Table: written in any state; the entry is read at load time, so a
    // write to a step that has not been reached yet shows up in this run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (cfg_we) begin
            tbl[cfg_idx] <= '{en: cfg_en, wr: cfg_wr, addr: cfg_addr, hold: cfg_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            en      <= 1'b0;
            wr      <= 1'b0;
            addr    <= '0;
            step    <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            en      <= en_d;
            wr      <= wr_d;
            addr    <= addr_d;
            step    <= step_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        len_d    = len_q;
        loop_d   = loop_q;
        en_d     = en;
        wr_d     = wr;
        addr_d   = addr;
        step_d   = step;
        done_d   = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;
        load_idx = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop && len_ok) begin
                    state_d = RUN;
                    len_d   = len;
                    loop_d  = loop;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // stop beats both advance and wrap
                if (stop) begin
                    clear = 1'b1;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (step_inc < len_q) begin
                    load     = 1'b1;
                    load_idx = step_inc[IDX_W-1:0];
                end else if (loop_q) begin
                    load = 1'b1;
                end else begin
                    clear  = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase

        if (load) begin
            en_d   = tbl[load_idx].en;
            wr_d   = tbl[load_idx].wr;
            addr_d = tbl[load_idx].addr;
            hold_d = tbl[load_idx].hold;
            step_d = load_idx;
        end

        if (clear) begin
            state_d = IDLE;
            en_d    = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            step_d  = '0;
            hold_d  = '0;
        end
    end

endmodule

// File: tb/tb_wave_seq.sv
// tb_wave_seq: directed bench for wave_seq. Each cycle's expected outputs are
// pushed to a scoreboard queue as the stimulus is driven and popped/compared
// one time unit after the following rising edge.
module tb_wave_seq;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 8;
    localparam int HOLD_W = 8;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [HOLD_W-1:0] cfg_hold = '0;
    logic [IDX_W:0]    len = '0;
    logic              loop = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              en, wr, busy, done;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  step;

    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              done;
        logic [IDX_W-1:0]  step;
    } obs_t;

    obs_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    wave_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr), .cfg_hold(cfg_hold),
        .len(len), .loop(loop), .start(start), .stop(stop),
        .en(en), .wr(wr), .addr(addr), .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    function automatic obs_t R(input logic e, input logic w, input int a, input int s);
        obs_t o;
        o.en = e; o.wr = w; o.addr = ADDR_W'(a); o.busy = 1'b1; o.done = 1'b0; o.step = IDX_W'(s);
        return o;
    endfunction

    function automatic obs_t I();
        return '0;
    endfunction

    function automatic obs_t D();
        obs_t o;
        o = '0;
        o.done = 1'b1;
        return o;
    endfunction

    // Advance one clock and check the outputs it produces.
    task automatic tick(input string tag, input obs_t e);
        obs_t got, want;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        got.en = en; got.wr = wr; got.addr = addr;
        got.busy = busy; got.done = done; got.step = step;
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got en=%0b wr=%0b addr=%0d busy=%0b done=%0b step=%0d, want en=%0b wr=%0b addr=%0d busy=%0b done=%0b step=%0d",
                   tag, got.en, got.wr, got.addr, got.busy, got.done, got.step,
                   want.en, want.wr, want.addr, want.busy, want.done, want.step);
        end
    endtask

    // Idle-time table write, no output check.
    task automatic wr_ent(input int idx, input logic e, input logic w, input int a, input int h);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = e; cfg_wr = w;
        cfg_addr = ADDR_W'(a); cfg_hold = HOLD_W'(h);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic base_table();
        wr_ent(0, 1, 1, 12, 0);
        wr_ent(1, 1, 1, 14, 0);
        wr_ent(2, 1, 0, 23, 0);
        wr_ent(3, 1, 0, 48, 0);
        wr_ent(4, 0, 0, 56, 0);
    endtask

    initial begin
        // reset state
        rst = 1'b1; start = 1'b1; len = 4'd5;
        tick("reset0", I());
        tick("reset1", I());
        rst = 1'b0; start = 1'b0;
        tick("post_reset_idle", I());

        base_table();

        // basic one-shot, len=5
        len = 4'd5; loop = 1'b0; start = 1'b1;
        tick("seq_s0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("seq_s1", R(1, 1, 14, 1));
        tick("seq_s2", R(1, 0, 23, 2));
        tick("seq_s3", R(1, 0, 48, 3));
        tick("seq_s4", R(0, 0, 56, 4));
        tick("seq_done", D());
        tick("seq_idle", I());

        // hold=2 on entry 1 stretches it to 3 cycles
        wr_ent(1, 1, 1, 14, 2);
        start = 1'b1;
        tick("hold_s0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("hold_s1a", R(1, 1, 14, 1));
        tick("hold_s1b", R(1, 1, 14, 1));
        tick("hold_s1c", R(1, 1, 14, 1));
        tick("hold_s2", R(1, 0, 23, 2));
        tick("hold_s3", R(1, 0, 48, 3));
        tick("hold_s4", R(0, 0, 56, 4));
        tick("hold_done", D());
        wr_ent(1, 1, 1, 14, 0);

        // invalid len starts are ignored
        len = 4'd0; start = 1'b1;
        tick("len0_ignored", I());
        len = 4'd9;
        tick("len9_ignored", I());
        start = 1'b0;

        // start during RUN is ignored
        len = 4'd5; start = 1'b1;
        tick("rerun_s0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("rerun_s1", R(1, 1, 14, 1));
        start = 1'b1; len = 4'd1; loop = 1'b1;
        tick("rerun_s2", R(1, 0, 23, 2));
        start = 1'b0; loop = 1'b0;
        tick("rerun_s3", R(1, 0, 48, 3));
        tick("rerun_s4", R(0, 0, 56, 4));
        tick("rerun_done", D());

        // write to a not-yet-loaded entry during the run
        len = 4'd5; start = 1'b1;
        tick("cfgrun_s0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("cfgrun_s1", R(1, 1, 14, 1));
        cfg_we = 1'b1; cfg_idx = 3'd4; cfg_en = 1'b0; cfg_wr = 1'b0;
        cfg_addr = 6'd33; cfg_hold = '0;
        tick("cfgrun_s2", R(1, 0, 23, 2));
        cfg_we = 1'b0;
        tick("cfgrun_s3", R(1, 0, 48, 3));
        tick("cfgrun_s4", R(0, 0, 33, 4));
        tick("cfgrun_done", D());

        // start and stop together in IDLE: stop wins
        len = 4'd2; loop = 1'b1; start = 1'b1; stop = 1'b1;
        tick("startstop_idle", I());
        stop = 1'b0;

        // len=2 loop: alternate 12/14, stop while on 14
        tick("loop_a0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("loop_b0", R(1, 1, 14, 1));
        tick("loop_a1", R(1, 1, 12, 0));
        tick("loop_b1", R(1, 1, 14, 1));
        tick("loop_a2", R(1, 1, 12, 0));
        tick("loop_b2", R(1, 1, 14, 1));
        stop = 1'b1;
        tick("loop_stop", I());
        stop = 1'b0;
        tick("loop_stop_idle", I());

        // len=1 loop holds entry 0 and re-reads it on every wrap
        len = 4'd1; loop = 1'b1; start = 1'b1;
        tick("len1_a", R(1, 1, 12, 0));
        start = 1'b0;
        tick("len1_b", R(1, 1, 12, 0));
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_wr = 1'b0;
        cfg_addr = 6'd20; cfg_hold = '0;
        tick("len1_c", R(1, 1, 12, 0));
        cfg_we = 1'b0;
        tick("len1_reread", R(1, 0, 20, 0));
        stop = 1'b1;
        tick("len1_stop", I());
        stop = 1'b0;

        // max hold lasts 2^HOLD_W cycles
        wr_ent(0, 1, 0, 7, 255);
        len = 4'd1; loop = 1'b0; start = 1'b1;
        tick("maxhold_first", R(1, 0, 7, 0));
        start = 1'b0;
        for (int i = 1; i < 256; i++) tick("maxhold", R(1, 0, 7, 0));
        tick("maxhold_done", D());

        // reset mid-run at step 3, also overriding a table write
        wr_ent(0, 1, 1, 12, 0);
        len = 4'd5; start = 1'b1;
        tick("rst_s0", R(1, 1, 12, 0));
        start = 1'b0;
        tick("rst_s1", R(1, 1, 14, 1));
        tick("rst_s2", R(1, 0, 23, 2));
        tick("rst_s3", R(1, 0, 48, 3));
        rst = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 6'd9; cfg_en = 1'b1;
        tick("rst_clear", I());
        rst = 1'b0; cfg_we = 1'b0;
        len = 4'd1; loop = 1'b0; start = 1'b1;
        tick("rst_zero_entry", R(0, 0, 0, 0));
        start = 1'b0;
        tick("rst_zero_done", D());
        tick("rst_final_idle", I());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
